// File: rtl/fp_mult_seq_ctrl.sv
// ---------------------------------------------------------------------------
// fp_mult_seq_ctrl
//
// Sequential mini-float multiplier for the GP02 float datapath. Two packed
// operands {sign, exp, mant} are accepted over a valid/ready handshake. The
// product is formed with a biased exponent add and a shift-add mantissa
// multiply (one multiplier bit per cycle, LSB first). The product is then
// normalised and truncated. Zero operands take a fast path, and overflow or
// underflow results are saturated or flushed.
//
// Ports
//   clk          in   1        single clock, rising edge
//   i_reset      in   1        synchronous, active-high reset
//   i_valid      in   1        operand pair valid
//   o_ready      out  1        operands can be accepted (IDLE only)
//   i_data_a     in   NB_DATA  operand A {sign, exp, mant}
//   i_data_b     in   NB_DATA  operand B {sign, exp, mant}
//   o_valid      out  1        result valid, held until i_ready
//   i_ready      in   1        consumer accepts the result
//   o_data       out  NB_DATA  product {sign, exp, mant}
//   o_overflow   out  1        result saturated, qualified by o_valid
//   o_underflow  out  1        result flushed to zero, qualified by o_valid
//
// Latency: accept at T -> o_valid at T+NB_MANT+3, or at T+1 for a zero operand.
// ---------------------------------------------------------------------------
//
// state  | meaning
// -------+------------------------------------------------------------------
// IDLE   | o_ready=1, waiting for an operand pair
// MUL    | shift-add mantissa multiply, NB_MANT+1 cycles
// NORM   | normalise, truncate, range-check and pack the result
// DONE   | o_valid=1, result held until i_ready
// ---------------------------------------------------------------------------

module fp_mult_seq_ctrl #(
   parameter int NB_EXP  = 4,
   parameter int NB_MANT = 3,
   parameter int BIAS    = 7
) (
   input  logic                            clk,
   input  logic                            i_reset,
   input  logic                            i_valid,
   output logic                            o_ready,
   input  logic [1+NB_EXP+NB_MANT-1:0]     i_data_a,
   input  logic [1+NB_EXP+NB_MANT-1:0]     i_data_b,
   output logic                            o_valid,
   input  logic                            i_ready,
   output logic [1+NB_EXP+NB_MANT-1:0]     o_data,
   output logic                            o_overflow,
   output logic                            o_underflow
);

   localparam int NB_DATA = 1 + NB_EXP + NB_MANT;
   localparam int NB_M1   = NB_MANT + 1;
   localparam int NB_P    = 2 * NB_M1;
   localparam int NB_E    = NB_EXP + 2;
   localparam int NB_CNT  = (NB_M1 > 1) ? $clog2(NB_M1) : 1;

   localparam logic [NB_E-1:0]   BIAS_E   = NB_E'(BIAS);
   localparam logic [NB_E-1:0]   EXP_OVF  = NB_E'(2 ** NB_EXP);
   localparam logic [NB_CNT-1:0] CNT_LOAD = NB_CNT'(NB_MANT);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_NORM = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;

   logic                  r_sign;
   logic [NB_E-1:0]       r_exp;
   logic [NB_P-1:0]       r_mcand;
   logic [NB_M1-1:0]      r_mplier;
   logic [NB_P-1:0]       r_acc;
   logic [NB_CNT-1:0]     r_cnt;
   logic [NB_DATA-1:0]    r_data;
   logic                  r_ovf;
   logic                  r_unf;

   logic                  w_accept;
   logic                  w_sign_a;
   logic                  w_sign_b;
   logic [NB_EXP-1:0]     w_exp_a;
   logic [NB_EXP-1:0]     w_exp_b;
   logic [NB_MANT-1:0]    w_mant_a;
   logic [NB_MANT-1:0]    w_mant_b;
   logic                  w_zero_op;
   logic [NB_E-1:0]       w_exp_sum;
   logic                  w_mul_last;

   logic                  w_norm_shift;
   logic [NB_MANT-1:0]    w_mant_norm;
   logic [NB_E-1:0]       w_exp_norm;
   logic                  w_ovf_norm;
   logic                  w_unf_norm;
   logic [NB_DATA-1:0]    w_data_norm;

   // ------------------------------------------------------------------------
   // Operand decode at the accept edge
   // ------------------------------------------------------------------------
   assign w_sign_a  = i_data_a[NB_DATA-1];
   assign w_sign_b  = i_data_b[NB_DATA-1];
   assign w_exp_a   = i_data_a[NB_DATA-2 -: NB_EXP];
   assign w_exp_b   = i_data_b[NB_DATA-2 -: NB_EXP];
   assign w_mant_a  = i_data_a[NB_MANT-1:0];
   assign w_mant_b  = i_data_b[NB_MANT-1:0];

   // An exponent field of zero marks a zero operand; its mantissa is ignored.
   assign w_zero_op = (w_exp_a == '0) || (w_exp_b == '0);

   // Two guard bits hold the signed range of ea + eb - BIAS.
   assign w_exp_sum = NB_E'(w_exp_a) + NB_E'(w_exp_b) - BIAS_E;

   assign w_accept   = (r_state == S_IDLE) && i_valid;
   assign w_mul_last = (r_cnt == '0);

   // ------------------------------------------------------------------------
   // Normalise / range check (evaluated while in NORM)
   // ------------------------------------------------------------------------
   // The product of two values in [1,2) lies in [1,4). A set MSB means the
   // value is in [2,4), so shift by one more place and bump the exponent.
   assign w_norm_shift = r_acc[NB_P-1];
   assign w_mant_norm  = w_norm_shift ? r_acc[NB_P-2 -: NB_MANT]
                                      : r_acc[NB_P-3 -: NB_MANT];
   assign w_exp_norm   = r_exp + NB_E'(w_norm_shift);

   // The exponent is signed in NB_E bits. A negative value can never overflow.
   assign w_ovf_norm = !w_exp_norm[NB_E-1] && (w_exp_norm >= EXP_OVF);
   assign w_unf_norm =  w_exp_norm[NB_E-1] || (w_exp_norm == '0);

   always_comb begin
      w_data_norm = {r_sign, w_exp_norm[NB_EXP-1:0], w_mant_norm};
      if (w_ovf_norm) begin
         w_data_norm = {r_sign, {(NB_EXP+NB_MANT){1'b1}}};
      end else if (w_unf_norm) begin
         w_data_norm = {r_sign, {(NB_EXP+NB_MANT){1'b0}}};
      end
   end

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (i_reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (i_valid) begin
               w_state_nxt = w_zero_op ? S_DONE : S_MUL;
            end
         end
         S_MUL: begin
            if (w_mul_last) begin
               w_state_nxt = S_NORM;
            end
         end
         S_NORM: begin
            w_state_nxt = S_DONE;
         end
         S_DONE: begin
            if (i_ready) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // FSM: outputs
   // ------------------------------------------------------------------------
   always_comb begin
      o_ready     = 1'b0;
      o_valid     = 1'b0;
      case (r_state)
         S_IDLE:  o_ready = 1'b1;
         S_DONE:  o_valid = 1'b1;
         default: begin
            o_ready = 1'b0;
            o_valid = 1'b0;
         end
      endcase
      o_data      = r_data;
      o_overflow  = r_ovf;
      o_underflow = r_unf;
   end

   // ------------------------------------------------------------------------
   // Datapath
   // ------------------------------------------------------------------------
   // The bit counter is a down-counter loaded with NB_MANT at accept. MUL
   // exits when it reaches zero, so it rests at zero between operations.
   always_ff @(posedge clk) begin
      if (i_reset) begin
         r_sign   <= 1'b0;
         r_exp    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_data   <= '0;
         r_ovf    <= 1'b0;
         r_unf    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_sign   <= w_sign_a ^ w_sign_b;
                  r_exp    <= w_exp_sum;
                  r_mcand  <= NB_P'({1'b1, w_mant_a});
                  r_mplier <= {1'b1, w_mant_b};
                  r_acc    <= '0;
                  r_cnt    <= CNT_LOAD;
                  r_ovf    <= 1'b0;
                  r_unf    <= 1'b0;
                  // The zero fast path already knows its result: a signed zero.
                  r_data   <= {w_sign_a ^ w_sign_b, {(NB_EXP+NB_MANT){1'b0}}};
               end
            end
            S_MUL: begin
               if (r_mplier[0]) begin
                  r_acc <= r_acc + r_mcand;
               end
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               if (!w_mul_last) begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            S_NORM: begin
               r_data <= w_data_norm;
               r_ovf  <= w_ovf_norm;
               r_unf  <= w_unf_norm && !w_ovf_norm;
            end
            default: begin
               r_data <= r_data;
            end
         endcase
      end
   end

endmodule
